// File: rtl/tlb_array.sv
// tlb_array: fully associative translation lookaside buffer.
//
// The control register block loads an entry in two steps: a VA write tags the
// entry with a virtual page and ASID, and a PA write then fills in the
// physical page and flags and makes it valid. One lookup can be issued per
// cycle, and its registered result appears on the following cycle.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   update_va_en        tag entry update_index with update_value[31:12] and update_asid
//   update_pa_en        fill ppn/writable/global of a tagged entry from update_value
//   update_index        entry being updated
//   update_value        VA word: [31:12] vpn; PA word: [31:12] ppn, [1] writable, [0] global
//   update_asid         ASID that goes with a VA write
//   invalidate_all      empty every entry; takes priority over a same-cycle update
//   lookup_en           lookup request
//   lookup_va           virtual address to translate
//   lookup_asid         ASID of the requester
//   lookup_is_write     the access is a store
//   lookup_valid        result valid (one cycle after lookup_en)
//   lookup_hit          translation found
//   lookup_pa           translated physical address, 0 on a miss
//   lookup_write_fault  hit on a non-writable entry by a store
module tlb_array #(
  parameter int TLB_INDEX_BITS = 4,
  parameter int ASID_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      update_va_en,
  input  logic                      update_pa_en,
  input  logic [TLB_INDEX_BITS-1:0] update_index,
  input  logic [31:0]               update_value,
  input  logic [ASID_BITS-1:0]      update_asid,
  input  logic                      invalidate_all,
  input  logic                      lookup_en,
  input  logic [31:0]               lookup_va,
  input  logic [ASID_BITS-1:0]      lookup_asid,
  input  logic                      lookup_is_write,
  output logic                      lookup_valid,
  output logic                      lookup_hit,
  output logic [31:0]               lookup_pa,
  output logic                      lookup_write_fault
);

  localparam int ENTRIES = 1 << TLB_INDEX_BITS;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    TAGGED = 2'd1,
    VALID  = 2'd2
  } entry_state_t;

  entry_state_t               state_q  [ENTRIES];
  entry_state_t               state_d  [ENTRIES];
  logic [19:0]                vpn_q    [ENTRIES];
  logic [ASID_BITS-1:0]       asid_q   [ENTRIES];
  logic [19:0]                ppn_q    [ENTRIES];
  logic                       writable_q [ENTRIES];
  logic                       global_q   [ENTRIES];

  // Bits of the update word that carry no entry state.
  logic unused_value_bits;
  assign unused_value_bits = ^update_value[11:2];

  // Per-entry state machine: next state.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      state_d[i] = state_q[i];
      if (invalidate_all) begin
        state_d[i] = EMPTY;
      end else if (update_index == TLB_INDEX_BITS'(i)) begin
        if (update_va_en) begin
          state_d[i] = TAGGED;
        end else if (update_pa_en && state_q[i] == TAGGED) begin
          state_d[i] = VALID;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= EMPTY;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Entry payload; only meaningful through the state, so it is not reset.
  // Updates dropped by invalidate_all leave the payload untouched as well.
  always_ff @(posedge clk) begin
    if (!invalidate_all && update_va_en) begin
      vpn_q[update_index]  <= update_value[31:12];
      asid_q[update_index] <= update_asid;
    end
    if (!invalidate_all && update_pa_en && state_q[update_index] == TAGGED) begin
      ppn_q[update_index]      <= update_value[31:12];
      writable_q[update_index] <= update_value[1];
      global_q[update_index]   <= update_value[0];
    end
  end

  // ---- stage p0: associative match on the current (pre-update) contents ----
  logic [ENTRIES-1:0]        match_p0;
  logic                      hit_p0;
  logic [TLB_INDEX_BITS-1:0] sel_p0;
  logic                      fault_p0;
  logic [31:0]               pa_p0;

  always_comb begin
    match_p0 = '0;
    sel_p0   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_p0[i] = (state_q[i] == VALID) &&
                    (vpn_q[i] == lookup_va[31:12]) &&
                    (global_q[i] || asid_q[i] == lookup_asid);
    end
    // Scan downward so the lowest matching index is the one left selected.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_p0[i]) begin
        sel_p0 = TLB_INDEX_BITS'(i);
      end
    end
    hit_p0   = |match_p0;
    pa_p0    = hit_p0 ? {ppn_q[sel_p0], lookup_va[11:0]} : 32'd0;
    fault_p0 = hit_p0 && lookup_is_write && !writable_q[sel_p0];
  end

  // ---- stage p1: registered lookup result ----
  logic        vld_p1;
  logic        hit_p1;
  logic [31:0] pa_p1;
  logic        fault_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      hit_p1   <= 1'b0;
      pa_p1    <= 32'd0;
      fault_p1 <= 1'b0;
    end else begin
      vld_p1   <= lookup_en;
      hit_p1   <= lookup_en && hit_p0;
      pa_p1    <= lookup_en ? pa_p0 : 32'd0;
      fault_p1 <= lookup_en && fault_p0;
    end
  end

  assign lookup_valid       = vld_p1;
  assign lookup_hit         = hit_p1;
  assign lookup_pa          = pa_p1;
  assign lookup_write_fault = fault_p1;

  // Simultaneous VA and PA writes indicate a broken update sequence.
  assert property (@(posedge clk) disable iff (reset) !(update_va_en && update_pa_en));

endmodule

// File: tb/tb_tlb_array.sv
module tb_tlb_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        update_va_en, update_pa_en;
  logic [3:0]  update_index;
  logic [31:0] update_value;
  logic [7:0]  update_asid;
  logic        invalidate_all;
  logic        lookup_en;
  logic [31:0] lookup_va;
  logic [7:0]  lookup_asid;
  logic        lookup_is_write;
  logic        lookup_valid, lookup_hit, lookup_write_fault;
  logic [31:0] lookup_pa;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  tlb_array #(.TLB_INDEX_BITS(4), .ASID_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .update_va_en(update_va_en), .update_pa_en(update_pa_en),
    .update_index(update_index), .update_value(update_value),
    .update_asid(update_asid), .invalidate_all(invalidate_all),
    .lookup_en(lookup_en), .lookup_va(lookup_va), .lookup_asid(lookup_asid),
    .lookup_is_write(lookup_is_write),
    .lookup_valid(lookup_valid), .lookup_hit(lookup_hit),
    .lookup_pa(lookup_pa), .lookup_write_fault(lookup_write_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic va_write(input logic [3:0] idx, input logic [31:0] val, input logic [7:0] asid);
    update_va_en = 1'b1; update_index = idx; update_value = val; update_asid = asid;
    tick();
    update_va_en = 1'b0;
  endtask

  task automatic pa_write(input logic [3:0] idx, input logic [31:0] val);
    update_pa_en = 1'b1; update_index = idx; update_value = val;
    tick();
    update_pa_en = 1'b0;
  endtask

  // Issue one lookup; on return the registered result is on the outputs.
  task automatic lookup(input logic [31:0] va, input logic [7:0] asid, input logic wr);
    lookup_en = 1'b1; lookup_va = va; lookup_asid = asid; lookup_is_write = wr;
    tick();
    lookup_en = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic hit, input logic [31:0] pa, input logic wf);
    chk({tag, "_valid"}, {31'd0, lookup_valid}, 32'd1);
    chk({tag, "_hit"},   {31'd0, lookup_hit}, {31'd0, hit});
    chk({tag, "_pa"},    lookup_pa, pa);
    chk({tag, "_wf"},    {31'd0, lookup_write_fault}, {31'd0, wf});
  endtask

  initial begin
    reset = 1'b1;
    update_va_en = 0; update_pa_en = 0; update_index = 0; update_value = 0;
    update_asid = 0; invalidate_all = 0; lookup_en = 0; lookup_va = 0;
    lookup_asid = 0; lookup_is_write = 0;
    tick(); tick();
    chk("rst_valid", {31'd0, lookup_valid}, 32'd0);
    chk("rst_hit",   {31'd0, lookup_hit}, 32'd0);
    chk("rst_pa",    lookup_pa, 32'd0);
    chk("rst_wf",    {31'd0, lookup_write_fault}, 32'd0);
    reset = 1'b0;
    tick();

    // Load and hit
    va_write(4'd3, 32'h0040_2000, 8'd5);
    pa_write(4'd3, 32'h1234_5002);
    lookup(32'h0040_2abc, 8'd5, 1'b0);
    chk_result("load", 1'b1, 32'h1234_5abc, 1'b0);
    tick();
    chk("load_pulse_valid", {31'd0, lookup_valid}, 32'd0);
    chk("load_pulse_hit",   {31'd0, lookup_hit}, 32'd0);
    chk("load_pulse_pa",    lookup_pa, 32'd0);

    // ASID mismatch, then global entry
    lookup(32'h0040_2abc, 8'd6, 1'b0);
    chk_result("asid_miss", 1'b0, 32'd0, 1'b0);
    va_write(4'd3, 32'h0040_2000, 8'd5);
    pa_write(4'd3, 32'h1234_5003);
    lookup(32'h0040_2abc, 8'd6, 1'b0);
    chk_result("global", 1'b1, 32'h1234_5abc, 1'b0);

    // PA write to an empty entry is ignored
    pa_write(4'd7, 32'h5555_5002);
    lookup(32'h5555_5000, 8'd0, 1'b0);
    chk_result("pa_empty", 1'b0, 32'd0, 1'b0);

    // Re-tag of a valid entry hides it until the PA write
    va_write(4'd3, 32'h0040_2000, 8'd5);
    lookup(32'h0040_2abc, 8'd5, 1'b0);
    chk_result("retag", 1'b0, 32'd0, 1'b0);
    pa_write(4'd3, 32'h1234_5000);
    lookup(32'h0040_2abc, 8'd5, 1'b1);
    chk_result("ro_store", 1'b1, 32'h1234_5abc, 1'b1);
    va_write(4'd3, 32'h0040_2000, 8'd5);
    pa_write(4'd3, 32'h1234_5002);
    lookup(32'h0040_2abc, 8'd5, 1'b1);
    chk_result("rw_store", 1'b1, 32'h1234_5abc, 1'b0);

    // invalidate_all beats a same-cycle PA write
    va_write(4'd2, 32'h0077_7000, 8'd1);
    invalidate_all = 1'b1; update_pa_en = 1'b1; update_index = 4'd2; update_value = 32'h0088_8002;
    tick();
    invalidate_all = 1'b0; update_pa_en = 1'b0;
    lookup(32'h0077_7123, 8'd1, 1'b0);
    chk_result("inv_pa", 1'b0, 32'd0, 1'b0);
    lookup(32'h0040_2abc, 8'd5, 1'b0);
    chk_result("inv_clr", 1'b0, 32'd0, 1'b0);

    // Lookup alongside invalidate_all sees old contents; the next one does not
    va_write(4'd3, 32'h0040_2000, 8'd5);
    pa_write(4'd3, 32'h1234_5002);
    invalidate_all = 1'b1;
    lookup_en = 1'b1; lookup_va = 32'h0040_2abc; lookup_asid = 8'd5; lookup_is_write = 1'b0;
    tick();
    invalidate_all = 1'b0;
    chk_result("inv_same", 1'b1, 32'h1234_5abc, 1'b0);
    tick();
    lookup_en = 1'b0;
    chk_result("inv_next", 1'b0, 32'd0, 1'b0);

    // Duplicates: lowest index wins regardless of load order
    va_write(4'd9, 32'h0abc_d000, 8'd0);
    pa_write(4'd9, 32'h2222_2002);
    va_write(4'd4, 32'h0abc_d000, 8'd0);
    pa_write(4'd4, 32'h1111_1002);
    lookup(32'h0abc_d123, 8'd0, 1'b0);
    chk_result("prio", 1'b1, 32'h1111_1123, 1'b0);
    va_write(4'd4, 32'h0abc_d000, 8'd0);
    lookup(32'h0abc_d123, 8'd0, 1'b0);
    chk_result("prio_hi", 1'b1, 32'h2222_2123, 1'b0);

    // Back-to-back lookups
    begin
      int pulses = 0;
      for (int i = 0; i < 16; i++) begin
        lookup_en = 1'b1; lookup_va = 32'h0abc_d000 + 32'(i * 8); lookup_asid = 8'd0;
        tick();
        if (lookup_valid) pulses++;
        chk("b2b_pa", lookup_pa, 32'h2222_2000 + 32'(i * 8));
      end
      lookup_en = 1'b0;
      tick();
      chk("b2b_pulses", 32'(pulses), 32'd16);
      chk("b2b_end", {31'd0, lookup_valid}, 32'd0);
    end

    // Reset in the middle of a lookup stream
    lookup_en = 1'b1; lookup_va = 32'h0abc_d456; lookup_asid = 8'd0;
    tick();
    chk("pre_rst_valid", {31'd0, lookup_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, lookup_valid}, 32'd0);
    chk("mid_rst_hit",   {31'd0, lookup_hit}, 32'd0);
    chk("mid_rst_pa",    lookup_pa, 32'd0);
    tick();
    reset = 1'b0;
    lookup_en = 1'b0;
    tick();
    lookup(32'h0abc_d456, 8'd0, 1'b0);
    chk_result("post_rst", 1'b0, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
